// File: rtl/reg_rate_bridge.sv
// Register bridge: fast-clock (clk) hold-until-ready slave to slow-clock (clk_2) strobe master.
// Define REG_RATE_TIMEOUT_EN to abort accesses the master leaves unanswered for TIMEOUT cycles.
module reg_rate_bridge #(
    parameter int unsigned    AW      = 10,
    parameter int unsigned    DW      = 32,
    parameter int unsigned    RATIO   = 2,
    parameter int unsigned    TIMEOUT = 64,
    parameter logic [DW-1:0]  TO_DATA = DW'(32'hDEADBEEF)
) (
    input  logic          clk,
    input  logic          clk_2,
    input  logic          rst,
    input  logic [AW-1:0] reg_s_addr,
    input  logic          reg_s_rd,
    input  logic          reg_s_wr,
    input  logic [DW-1:0] reg_s_writedata,
    output logic          reg_s_ready,
    output logic [DW-1:0] reg_s_readdata,
    output logic          reg_s_err,
    output logic [AW-1:0] reg_m_addr,
    output logic          reg_m_rd,
    output logic          reg_m_wr,
    input  logic          reg_m_ready,
    output logic [DW-1:0] reg_m_writedata,
    input  logic [DW-1:0] reg_m_readdata
);

    typedef enum logic {StIdle, StAccess} state_t;

    // Fast-domain request hold registers and handshake toggles
    logic          r_busy;
    logic          r_req_tgl;
    logic          r_resp_seen;
    logic          r_hold_wr;
    logic [AW-1:0] r_hold_addr;
    logic [DW-1:0] r_hold_wdata;

    // Slow-domain state and response registers
    state_t        r_state;
    logic          r_req_seen;
    logic          r_resp_tgl;
    logic          r_m_err;
    logic [DW-1:0] r_m_rdata;

    logic          w_capture;
    logic          w_resp;
    logic          w_unused_cfg;

    assign w_capture = (reg_s_rd | reg_s_wr) & ~r_busy & ~reg_s_ready;
    assign w_resp    = r_resp_tgl != r_resp_seen;

    // Crossings rely on phase-aligned clocks: only toggles and held-stable registers cross.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_req_tgl      <= 1'b0;
            r_resp_seen    <= 1'b0;
            r_hold_wr      <= 1'b0;
            r_hold_addr    <= '0;
            r_hold_wdata   <= '0;
            reg_s_ready    <= 1'b0;
            reg_s_readdata <= '0;
            reg_s_err      <= 1'b0;
        end else begin
            reg_s_ready <= w_resp;
            if (w_capture) begin
                r_hold_addr  <= reg_s_addr;
                r_hold_wdata <= reg_s_writedata;
                r_hold_wr    <= reg_s_wr;
                r_busy       <= 1'b1;
                r_req_tgl    <= ~r_req_tgl;
            end
            if (w_resp) begin
                r_resp_seen <= r_resp_tgl;
                r_busy      <= 1'b0;
                reg_s_err   <= r_m_err;
                if (!r_hold_wr || r_m_err) begin
                    reg_s_readdata <= r_m_rdata;
                end
            end
        end
    end

`ifdef REG_RATE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_to_cnt;
`endif

    always_ff @(posedge clk_2) begin
        if (rst) begin
            r_state         <= StIdle;
            r_req_seen      <= 1'b0;
            r_resp_tgl      <= 1'b0;
            r_m_err         <= 1'b0;
            r_m_rdata       <= '0;
            reg_m_addr      <= '0;
            reg_m_writedata <= '0;
            reg_m_rd        <= 1'b0;
            reg_m_wr        <= 1'b0;
`ifdef REG_RATE_TIMEOUT_EN
            r_to_cnt        <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_req_tgl != r_req_seen) begin
                        r_req_seen      <= r_req_tgl;
                        reg_m_addr      <= r_hold_addr;
                        reg_m_writedata <= r_hold_wdata;
                        reg_m_wr        <= r_hold_wr;
                        reg_m_rd        <= ~r_hold_wr;
                        r_state         <= StAccess;
`ifdef REG_RATE_TIMEOUT_EN
                        r_to_cnt        <= '0;
`endif
                    end
                end
                StAccess: begin
                    if (reg_m_ready) begin
                        reg_m_rd   <= 1'b0;
                        reg_m_wr   <= 1'b0;
                        r_m_err    <= 1'b0;
                        r_resp_tgl <= ~r_resp_tgl;
                        r_state    <= StIdle;
                        if (reg_m_rd) begin
                            r_m_rdata <= reg_m_readdata;
                        end
                    end
`ifdef REG_RATE_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        reg_m_rd   <= 1'b0;
                        reg_m_wr   <= 1'b0;
                        r_m_err    <= 1'b1;
                        r_m_rdata  <= TO_DATA;
                        r_resp_tgl <= ~r_resp_tgl;
                        r_state    <= StIdle;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // RATIO only shapes timing constraints; timeout settings are idle without the timeout build.
`ifdef REG_RATE_TIMEOUT_EN
    assign w_unused_cfg = ^RATIO;
`else
    assign w_unused_cfg = ^{RATIO, TIMEOUT, TO_DATA};
`endif

endmodule

// File: tb/tb_reg_rate_bridge.sv
// Self-checking bench for reg_rate_bridge: directed cases plus randomized accesses checked
// against a register-map reference model and a behavioural slow-side peripheral.
module tb_reg_rate_bridge;

    localparam int unsigned   AW      = 10;
    localparam int unsigned   DW      = 32;
    localparam int unsigned   RATIO   = 2;
    localparam int unsigned   TIMEOUT = 8;
    localparam logic [DW-1:0] TO_DATA = 32'hDEADBEEF;

    logic          clk;
    logic          clk_2;
    logic          rst;
    logic [AW-1:0] reg_s_addr;
    logic          reg_s_rd;
    logic          reg_s_wr;
    logic [DW-1:0] reg_s_writedata;
    logic          reg_s_ready;
    logic [DW-1:0] reg_s_readdata;
    logic          reg_s_err;
    logic [AW-1:0] reg_m_addr;
    logic          reg_m_rd;
    logic          reg_m_wr;
    logic          reg_m_ready = 1'b0;
    logic [DW-1:0] reg_m_writedata;
    logic [DW-1:0] reg_m_readdata = '0;

    int checks = 0;
    int errors = 0;

    reg_rate_bridge #(
        .AW      (AW),
        .DW      (DW),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT),
        .TO_DATA (TO_DATA)
    ) u_dut (
        .clk             (clk),
        .clk_2           (clk_2),
        .rst             (rst),
        .reg_s_addr      (reg_s_addr),
        .reg_s_rd        (reg_s_rd),
        .reg_s_wr        (reg_s_wr),
        .reg_s_writedata (reg_s_writedata),
        .reg_s_ready     (reg_s_ready),
        .reg_s_readdata  (reg_s_readdata),
        .reg_s_err       (reg_s_err),
        .reg_m_addr      (reg_m_addr),
        .reg_m_rd        (reg_m_rd),
        .reg_m_wr        (reg_m_wr),
        .reg_m_ready     (reg_m_ready),
        .reg_m_writedata (reg_m_writedata),
        .reg_m_readdata  (reg_m_readdata)
    );

    // Both clocks from one process so their rising edges coincide in the same time step.
    int ph = 0;
    initial begin
        clk   = 1'b0;
        clk_2 = 1'b0;
        forever begin
            #5;
            clk = 1'b1;
            if (ph == 0) clk_2 = 1'b1;
            else if (ph == RATIO / 2) clk_2 = 1'b0;
            ph = (ph == RATIO - 1) ? 0 : ph + 1;
            #5;
            clk = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'h5A5A_0000 ^ DW'(a * 40503);
    endfunction

    // Slow-side peripheral: answers after m_wait cycles, or never when m_never is set.
    logic [DW-1:0] periph [int];
    int            m_wait = 0;
    bit            m_never = 0;
    int            m_cnt = 0;
    bit            m_active = 0;
    int            n_rd_stb = 0;
    int            n_wr_stb = 0;
    int            hi_cycles = 0;
    int            gap = 1000;
    int            last_gap = 1000;
    int            unstable = 0;
    logic [AW-1:0] stb_addr = '0;
    logic [DW-1:0] stb_wdata = '0;
    logic          stb_rd = 1'b0;

    always @(posedge clk_2) begin
        #1;
        if (reg_m_rd || reg_m_wr) begin
            if (!m_active) begin
                m_active  = 1;
                m_cnt     = 0;
                hi_cycles = 0;
                last_gap  = gap;
                gap       = 0;
                stb_addr  = reg_m_addr;
                stb_wdata = reg_m_writedata;
                stb_rd    = reg_m_rd;
                if (reg_m_rd) n_rd_stb++;
                if (reg_m_wr) n_wr_stb++;
            end else begin
                m_cnt++;
            end
            hi_cycles++;
            if (reg_m_addr !== stb_addr || reg_m_rd !== stb_rd || reg_m_writedata !== stb_wdata)
                unstable++;
            reg_m_ready = !m_never && (m_cnt >= m_wait);
            if (reg_m_ready && reg_m_wr) periph[int'(reg_m_addr)] = reg_m_writedata;
            if (reg_m_ready)
                reg_m_readdata = periph.exists(int'(reg_m_addr)) ? periph[int'(reg_m_addr)]
                                                                  : init_val(int'(reg_m_addr));
            else
                reg_m_readdata = $urandom();
        end else begin
            m_active       = 0;
            gap++;
            reg_m_ready    = 1'b0;
            reg_m_readdata = $urandom();
        end
    end

    // Reference register map and model of the slave readdata register.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] last_rdata = '0;
    bit            exp_timeout = 0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drop_req();
        reg_s_rd = 1'b0;
        reg_s_wr = 1'b0;
    endtask

    // Caller is at a clk negedge. hold: 0 drop on ready, 1 hold through ready cycle, 2 drop early.
    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int hold, input int w);
        int            k;
        int            bound;
        bit            seen;
        int            n_rd0;
        int            n_wr0;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        n_rd0   = n_rd_stb;
        n_wr0   = n_wr_stb;
        m_wait  = w;
        exp_err = exp_timeout;
        if (exp_timeout) exp_data = TO_DATA;
        else if (wr) exp_data = last_rdata;
        else exp_data = ref_read(a);
        bound = exp_timeout ? (TIMEOUT + 2) * RATIO + 2 : (3 + w) * RATIO + 2;
        reg_s_rd        = rd;
        reg_s_wr        = wr;
        reg_s_addr      = a;
        reg_s_writedata = d;
        seen = 0;
        k    = 0;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            if (hold == 2 && k == 1) drop_req();
            if (reg_s_ready) seen = 1;
        end
        check("ready_seen", seen, 1);
        if (seen) begin
            check("latency", k <= bound, 1);
            check("readdata", reg_s_readdata, exp_data);
            check("err", reg_s_err, exp_err);
            if (hold != 1) drop_req();
            @(negedge clk);
            check("ready_pulse", reg_s_ready, 0);
        end
        drop_req();
        check("rd_strobes", n_rd_stb - n_rd0, wr ? 0 : 1);
        check("wr_strobes", n_wr_stb - n_wr0, wr ? 1 : 0);
        check("stb_addr", stb_addr, a);
        if (wr) check("stb_wdata", stb_wdata, d);
        last_rdata = exp_data;
        if (wr && !exp_timeout) ref_mem[int'(a)] = d;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        int            n0;
        int            k;
        int            pulses;
        bit            got;
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;

        rst             = 1'b1;
        reg_s_rd        = 1'b0;
        reg_s_wr        = 1'b0;
        reg_s_addr      = '0;
        reg_s_writedata = '0;
        repeat (2 * RATIO + 1) @(negedge clk);
        check("rst_ready", reg_s_ready, 0);
        check("rst_rdata", reg_s_readdata, 0);
        check("rst_err", reg_s_err, 0);
        check("rst_m_strobe", {reg_m_rd, reg_m_wr}, 0);
        check("rst_m_addr", reg_m_addr, 0);
        check("rst_m_wdata", reg_m_writedata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read of a known value with a one-cycle master
        access(1'b0, 1'b1, 10'h12A, 32'hCAFE0001, 0, 0);
        idle_gap();
        access(1'b1, 1'b0, 10'h12A, '0, 0, 0);
        check("t1_rdata", reg_s_readdata, 32'hCAFE0001);

        // Write held through the ready cycle must not be captured twice
        access(1'b0, 1'b1, 10'h003, 32'h55AA00FF, 1, 1);
        n0 = n_wr_stb;
        repeat (6 * RATIO) @(negedge clk);
        check("t2_no_recapture", n_wr_stb - n0, 0);
        check("t2_wdata", stb_wdata, 32'h55AA00FF);

        // Back-to-back read then write
        access(1'b1, 1'b0, 10'h003, '0, 0, 0);
        access(1'b0, 1'b1, 10'h007, 32'h0BAD_F00D, 0, 0);
        check("t3_gap", last_gap >= 1, 1);

        // rd and wr together resolve to a write
        idle_gap();
        access(1'b1, 1'b1, 10'h00A, 32'h1234_5678, 0, 2);
        access(1'b1, 1'b0, 10'h00A, '0, 0, 0);

        // Slave withdraws the request early
        access(1'b1, 1'b0, 10'h007, '0, 2, 3);

        // Reset in the middle of an access
        m_never    = 1;
        reg_s_addr = 10'h005;
        reg_s_rd   = 1'b1;
        got        = 0;
        for (int i = 0; i < 20 * RATIO && !got; i++) begin
            @(negedge clk);
            if (reg_m_rd) got = 1;
        end
        check("t6_strobe_seen", got, 1);
        repeat (2) @(posedge clk_2);
        #1;
        rst      = 1'b1;
        reg_s_rd = 1'b0;
        @(posedge clk_2);
        #1;
        check("t6_strobe_low", {reg_m_rd, reg_m_wr}, 0);
        check("t6_rdata", reg_s_readdata, 0);
        check("t6_m_addr", reg_m_addr, 0);
        check("t6_ready", reg_s_ready, 0);
        rst     = 1'b0;
        m_never = 0;
        pulses  = 0;
        for (int i = 0; i < 6 * RATIO; i++) begin
            @(negedge clk);
            if (reg_s_ready) pulses++;
        end
        check("t6_no_ready", pulses, 0);
        last_rdata = '0;
        access(1'b1, 1'b0, 10'h005, '0, 0, 1);

`ifdef REG_RATE_TIMEOUT_EN
        // Unanswered access times out; ready on the final cycle still completes normally
        exp_timeout = 1;
        m_never     = 1;
        access(1'b1, 1'b0, 10'h00C, '0, 0, 0);
        check("t5_hi_cycles", hi_cycles, TIMEOUT);
        exp_timeout = 0;
        m_never     = 0;
        access(1'b1, 1'b0, 10'h00D, '0, 0, TIMEOUT - 1);
        check("t5_edge_hi_cycles", hi_cycles, TIMEOUT);
        access(1'b0, 1'b1, 10'h00D, 32'h7777_0001, 0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = AW'($urandom_range(0, 15));
            idle_gap();
            access(rd, wr, a, $urandom(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        k = unstable;
        check("strobe_stable", k, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
